// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the LV1<->LV2 bus arbiter.
package cache_arb_pkg;

    localparam int unsigned MAX_CORES   = 4;
    localparam int unsigned CORE_ID_WID = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROC  = 2'd1,
        SNOOP = 2'd2,
        LV2   = 2'd3
    } arb_state_t;

    function automatic logic [MAX_CORES-1:0] core_onehot(input logic [CORE_ID_WID-1:0] id);
        core_onehot = MAX_CORES'(1) << id;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Circular first-one finder over four requesters, scanning upward from start.
module rr_pick4
    import cache_arb_pkg::*;
(
    input  logic [MAX_CORES-1:0]   req,
    input  logic [CORE_ID_WID-1:0] start,
    output logic                   valid,
    output logic [CORE_ID_WID-1:0] id
);

    logic [CORE_ID_WID-1:0] idx;

    // Scan from farthest to nearest so the nearest hit is the one left standing.
    always_comb begin
        valid = 1'b0;
        id    = start;
        idx   = start;
        for (int i = MAX_CORES - 1; i >= 0; i--) begin
            idx = CORE_ID_WID'(start + CORE_ID_WID'(i));
            if (req[idx]) begin
                valid = 1'b1;
                id    = idx;
            end
        end
    end

endmodule

// File: rtl/lv1_lv2_bus_arbiter.sv
// Round-robin owner arbiter for the shared LV1<->LV2 bus with nested snoop/LV2 grants.
// Optional grant-hold watchdog enabled by defining ARB_WATCHDOG_EN.
module lv1_lv2_bus_arbiter
    import cache_arb_pkg::*;
#(
    parameter int unsigned NUM_CORES      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [MAX_CORES-1:0] bus_lv1_lv2_req_proc,
    input  logic [MAX_CORES-1:0] bus_lv1_lv2_req_snoop,
    input  logic                 bus_lv1_lv2_req_lv2,
    output logic [MAX_CORES-1:0] bus_lv1_lv2_gnt_proc,
    output logic [MAX_CORES-1:0] bus_lv1_lv2_gnt_snoop,
    output logic                 bus_lv1_lv2_gnt_lv2,
    output logic                 arb_busy
`ifdef ARB_WATCHDOG_EN
    ,
    output logic                 arb_timeout_err
`endif
);

    if ((NUM_CORES != 2) && (NUM_CORES != 4)) begin : g_bad_cores
        $error("NUM_CORES must be 2 or 4");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    localparam logic [MAX_CORES-1:0] CORE_MASK = MAX_CORES'((1 << NUM_CORES) - 1);

    arb_state_t             state_q, state_d;
    logic [CORE_ID_WID-1:0] owner_q, owner_d;
    logic [CORE_ID_WID-1:0] snoop_id_q, snoop_id_d;
    logic [CORE_ID_WID-1:0] rr_ptr_q, rr_ptr_d;
    logic [MAX_CORES-1:0]   gnt_proc_q, gnt_proc_d;
    logic [MAX_CORES-1:0]   gnt_snoop_q, gnt_snoop_d;
    logic                   gnt_lv2_q, gnt_lv2_d;
    logic                   busy_q, busy_d;

    logic [MAX_CORES-1:0]   req_proc_m;
    logic [MAX_CORES-1:0]   req_snoop_m;
    logic [CORE_ID_WID-1:0] owner_inc;
    logic [CORE_ID_WID-1:0] next_ptr;
    logic                   proc_vld;
    logic [CORE_ID_WID-1:0] proc_id;
    logic                   snoop_vld;
    logic [CORE_ID_WID-1:0] snoop_id;

    assign req_proc_m  = bus_lv1_lv2_req_proc & CORE_MASK;
    assign req_snoop_m = bus_lv1_lv2_req_snoop & CORE_MASK & ~core_onehot(owner_q);
    assign owner_inc   = CORE_ID_WID'(owner_q + CORE_ID_WID'(1));
    assign next_ptr    = (owner_q == CORE_ID_WID'(NUM_CORES - 1)) ? '0 : owner_inc;

    rr_pick4 u_proc_pick (
        .req   (req_proc_m),
        .start (rr_ptr_q),
        .valid (proc_vld),
        .id    (proc_id)
    );

    rr_pick4 u_snoop_pick (
        .req   (req_snoop_m),
        .start (owner_inc),
        .valid (snoop_vld),
        .id    (snoop_id)
    );

`ifdef ARB_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            timeout_err_q, timeout_err_d;
    logic            wd_hit;

    // The cycle the counter would reach the limit is the last held grant cycle.
    assign wd_hit = (state_q != IDLE) && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        snoop_id_d  = snoop_id_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_proc_d  = gnt_proc_q;
        gnt_snoop_d = gnt_snoop_q;
        gnt_lv2_d   = gnt_lv2_q;

        case (state_q)
            IDLE: begin
                if (proc_vld) begin
                    owner_d    = proc_id;
                    gnt_proc_d = core_onehot(proc_id);
                    state_d    = PROC;
                end
            end
            PROC: begin
                if (!req_proc_m[owner_q]) begin
                    gnt_proc_d  = '0;
                    gnt_snoop_d = '0;
                    gnt_lv2_d   = 1'b0;
                    rr_ptr_d    = next_ptr;
                    state_d     = IDLE;
                end else if (snoop_vld) begin
                    snoop_id_d  = snoop_id;
                    gnt_snoop_d = core_onehot(snoop_id);
                    state_d     = SNOOP;
                end else if (bus_lv1_lv2_req_lv2) begin
                    gnt_lv2_d = 1'b1;
                    state_d   = LV2;
                end
            end
            SNOOP: begin
                if (!bus_lv1_lv2_req_snoop[snoop_id_q]) begin
                    gnt_snoop_d = '0;
                    state_d     = PROC;
                end
            end
            LV2: begin
                if (!bus_lv1_lv2_req_lv2) begin
                    gnt_lv2_d = 1'b0;
                    state_d   = PROC;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef ARB_WATCHDOG_EN
        timeout_err_d = timeout_err_q;
        if (wd_hit) begin
            gnt_proc_d    = '0;
            gnt_snoop_d   = '0;
            gnt_lv2_d     = 1'b0;
            rr_ptr_d      = next_ptr;
            state_d       = IDLE;
            timeout_err_d = 1'b1;
        end
        wd_cnt_d = ((state_d != state_q) || (state_q == IDLE)) ? '0 : WD_W'(wd_cnt_q + WD_W'(1));
`endif

        busy_d = (gnt_proc_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            snoop_id_q  <= '0;
            rr_ptr_q    <= '0;
            gnt_proc_q  <= '0;
            gnt_snoop_q <= '0;
            gnt_lv2_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef ARB_WATCHDOG_EN
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            snoop_id_q  <= snoop_id_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_proc_q  <= gnt_proc_d;
            gnt_snoop_q <= gnt_snoop_d;
            gnt_lv2_q   <= gnt_lv2_d;
            busy_q      <= busy_d;
`ifdef ARB_WATCHDOG_EN
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign bus_lv1_lv2_gnt_proc  = gnt_proc_q;
    assign bus_lv1_lv2_gnt_snoop = gnt_snoop_q;
    assign bus_lv1_lv2_gnt_lv2   = gnt_lv2_q;
    assign arb_busy              = busy_q;
`ifdef ARB_WATCHDOG_EN
    assign arb_timeout_err       = timeout_err_q;
`endif

    a_snoop_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(gnt_snoop_q));
    a_snoop_lv2_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !((gnt_snoop_q != '0) && gnt_lv2_q));
    a_sub_needs_proc: assert property (@(posedge clk) disable iff (!rst_n)
        ((gnt_snoop_q != '0) || gnt_lv2_q) |-> (gnt_proc_q != '0));

endmodule

// File: doc/lv1_lv2_bus_arbiter.md
# lv1_lv2_bus_arbiter

- Arbitrates the shared LV1↔LV2 bus (data_bus_lv1_lv2 / addr_bus_lv1_lv2) between the per-core LV1 processor-side requests, the per-core LV1 snoop responses and the LV2 cache.
- Drives the bus_lv1_lv2_gnt_proc, bus_lv1_lv2_gnt_snoop and bus_lv1_lv2_gnt_lv2 inputs of cache_top.
- Proc ownership rotates round-robin. Snoop and LV2 grants nest inside the active proc ownership, so one coherence transaction completes before the next core is granted.

## Interface
Parameters:
- NUM_CORES, 4 — active cores, 2 or 4. Request bits ≥ NUM_CORES are ignored; their grant bits are tied 0.
- TIMEOUT_CYCLES, 1024 — grant-hold watchdog limit. Used only with ARB_WATCHDOG_EN.

Ports:
- clk  in  1  — bus clock.
- rst_n  in  1  — reset; asynchronous, active-low.
- bus_lv1_lv2_req_proc  in  4  — per-core processor-side bus request.
- bus_lv1_lv2_req_snoop  in  4  — per-core snoop-response bus request.
- bus_lv1_lv2_req_lv2  in  1  — LV2 request to drive the bus.
- bus_lv1_lv2_gnt_proc  out  4  — one-hot-or-zero proc grant.
- bus_lv1_lv2_gnt_snoop  out  4  — one-hot-or-zero snoop grant.
- bus_lv1_lv2_gnt_lv2  out  1  — LV2 grant.
- arb_busy  out  1  — a proc owner exists.
- arb_timeout_err  out  1  — sticky watchdog flag. Present only with ARB_WATCHDOG_EN.

## Operation
- States: IDLE, PROC, SNOOP, LV2. Registers: owner[1:0], snoop_id[1:0], rr_ptr[1:0].
- IDLE
  - No req_proc: stay in IDLE.
  - Any masked req_proc: pick the first requester at or after rr_ptr (circular), set owner, assert gnt_proc[owner], go to PROC.
- PROC
  - If req_proc[owner]=0: drop all grants, rr_ptr←owner+1 (mod NUM_CORES), go to IDLE.
  - Else if any req_snoop[i] with i≠owner: grant the first such i circularly after owner, go to SNOOP.
  - Else if req_lv2: assert gnt_lv2, go to LV2.
  - Priority within PROC: release > snoop > lv2.
- SNOOP: gnt_proc[owner] and gnt_snoop[snoop_id] are held until req_snoop[snoop_id]=0, then drop gnt_snoop and return to PROC.
- LV2: gnt_proc[owner] and gnt_lv2 are held until req_lv2=0, then drop gnt_lv2 and return to PROC.
- Owner drops req_proc during SNOOP or LV2: ignored until the sub-grant ends. Release is then evaluated in PROC.
- req_snoop[owner] is never granted.
- Requests arriving outside their legal state are held by the requester and are not latched by the arbiter.
- Invariants, checked by assertion:
  - At most one gnt_snoop bit set.
  - gnt_snoop and gnt_lv2 never set together.
  - gnt_snoop or gnt_lv2 set implies gnt_proc set.
- Reset: all grants 0, arb_busy 0, arb_timeout_err 0, state IDLE, rr_ptr 0, owner 0.

## Timing
- All outputs are registered.
- Request sampled at edge N gives the grant visible after edge N+1 (1-cycle latency).
- Release:
  - Owner deasserts req in cycle N; gnt_proc falls after edge N+1.
  - IDLE lasts at least one cycle (turnaround).
  - The next proc grant appears after edge N+2 at the earliest.
- Sub-grant release: req drop sampled at N; sub-grant falls after N+1; the next sub-grant can be issued at N+2 earliest.
- Simultaneous proc requests resolve by rr_ptr only. Every active core waits at most NUM_CORES−1 ownerships.
- rst_n asserted mid-transaction: all grants clear immediately (asynchronously). Arbitration restarts from rr_ptr=0 after deassertion.

## Configuration
- ARB_WATCHDOG_EN defined:
  - A $clog2(TIMEOUT_CYCLES+1)-bit counter clears on every state change and increments while in PROC, SNOOP or LV2.
  - When it reaches TIMEOUT_CYCLES: all grants are forced to 0, state goes to IDLE, rr_ptr←owner+1, and arb_timeout_err is set.
  - arb_timeout_err clears only on reset.
- ARB_WATCHDOG_EN undefined: no counter, no arb_timeout_err port, grants are held indefinitely.

## Structure
- Package cache_arb_pkg:
  - arb_state_t enum (IDLE, PROC, SNOOP, LV2).
  - MAX_CORES=4.
  - CORE_ID_WID=2.
- Sub-module rr_pick4: combinational circular first-one finder. Inputs: 4-bit req and 2-bit start. Outputs: valid and 2-bit id.
  - Instantiated twice: proc select with start=rr_ptr; snoop select with start=owner+1 and the owner bit masked.

## Test plan
- Reset, then req_proc=4'b0001 at cycle 2 → gnt_proc=4'b0001 at cycle 3 and arb_busy=1. Deassert at cycle 6 → gnt_proc=0 at cycle 7.
- req_proc=4'b1111 held constant, each owner holding 4 cycles → grant order 0,1,2,3,0 with one idle cycle between ownerships.
- Owner 1 granted; req_snoop=4'b0110 → gnt_snoop=4'b0100 (core 1 masked, core 2 wins), gnt_proc stays 4'b0010. Snoop drop → gnt_snoop clears, then lv2 request served.
- Owner 2 in PROC with req_snoop[0] and req_lv2 both raised → gnt_snoop=4'b0001 first, gnt_lv2 only after snoop release.
- NUM_CORES=2, req_proc=4'b1100 → no grant ever. Apply rst_n low during LV2 → gnt_lv2 and gnt_proc drop in the same cycle.
- ARB_WATCHDOG_EN, TIMEOUT_CYCLES=8: owner 0 holds req for 20 cycles → grants forced 0 after 8 held cycles, arb_timeout_err=1, next grant goes to core 1 if it is requesting.
